// File: rtl/dff_pipe_pkg.sv
// Shared constants and bus shapes for the dff_pipe delay primitive and its wrappers.
package dff_pipe_pkg;

    localparam int RETIME_OFF = 0;
    localparam int RETIME_ON  = 1;

    // Element array shape used by the dff3 wrapper (24-bit x [3][3]).
    localparam int unsigned DFF3_WIDTH = 24;
    localparam int unsigned DFF3_SIZE1 = 3;
    localparam int unsigned DFF3_SIZE2 = 3;
    typedef logic [DFF3_SIZE1-1:0][DFF3_SIZE2-1:0][DFF3_WIDTH-1:0] dff3_bus_t;

    function automatic bit retime_is_valid(input int status);
        return (status == RETIME_OFF) || (status == RETIME_ON);
    endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One enabled, synchronously cleared register holding a full element array.
module dff_pipe_stage
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int ARRAY_SIZE1 = 1,
    parameter int ARRAY_SIZE2 = 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            en,
    input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] d,
    output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] q
);

    logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] data_d;
    logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] data_q;

    // Clear wins over enable; otherwise hold.
    always_comb begin
        data_d = data_q;
        if (reset) begin
            data_d = '0;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/dff_pipe.sv
// Fixed-latency delay line for scalar / 1-D / 2-D buses; depth 0 is a wire.
// Define DFF_PIPE_ASSERT_EN to compile in parameter and runtime checks.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int ARRAY_SIZE1   = 1,
    parameter int ARRAY_SIZE2   = 1,
    parameter int PIPE_DEPTH    = 1,
    parameter int RETIME_STATUS = RETIME_OFF
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            en,
    input  logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] in,
    output logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] out
);

    typedef logic [ARRAY_SIZE1-1:0][ARRAY_SIZE2-1:0][WIDTH-1:0] bus_t;

    // Retiming is a synthesis hint only; it never changes behaviour.
    localparam int RETIME_UNUSED = RETIME_STATUS;

    if (PIPE_DEPTH == 0) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, reset, en};
        assign out         = in;
    end else begin : g_pipe
        bus_t stage_q [PIPE_DEPTH];

        for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_first
                dff_pipe_stage #(
                    .WIDTH      (WIDTH),
                    .ARRAY_SIZE1(ARRAY_SIZE1),
                    .ARRAY_SIZE2(ARRAY_SIZE2)
                ) u_stage (
                    .clk  (clk),
                    .reset(reset),
                    .en   (en),
                    .d    (in),
                    .q    (stage_q[k])
                );
            end else begin : g_next
                dff_pipe_stage #(
                    .WIDTH      (WIDTH),
                    .ARRAY_SIZE1(ARRAY_SIZE1),
                    .ARRAY_SIZE2(ARRAY_SIZE2)
                ) u_stage (
                    .clk  (clk),
                    .reset(reset),
                    .en   (en),
                    .d    (stage_q[k-1]),
                    .q    (stage_q[k])
                );
            end
        end

        assign out = stage_q[PIPE_DEPTH-1];
    end

`ifdef DFF_PIPE_ASSERT_EN
    if (PIPE_DEPTH < 0 || WIDTH < 1 || ARRAY_SIZE1 < 1 || ARRAY_SIZE2 < 1 ||
        !retime_is_valid(RETIME_UNUSED)) begin : g_param_chk
        $error("dff_pipe: illegal parameter combination");
    end

    a_in_known: assert property (@(posedge clk) (en && !reset) |-> !$isunknown(in))
        else $error("dff_pipe: X/Z on in while enabled");

    if (PIPE_DEPTH > 0) begin : g_rst_chk
        a_rst_zero: assert property (@(posedge clk) reset |=> (out == '0))
            else $error("dff_pipe: out not cleared after reset");
    end
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: depths 3 and 2 on a 24x[3][3] bus, depth 1 on 32 bits, depth 0 on 1x[2].
module tb_dff_pipe;
    import dff_pipe_pkg::*;

    typedef dff3_bus_t bus3_t;
    typedef logic [0:0][0:0][31:0] bus1_t;
    typedef logic [1:0][0:0][0:0] bus0_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  en;
    bus3_t in3, out3, out2;
    bus1_t in1, out1;
    bus0_t in0, out0;

    int checks   = 0;
    int failures = 0;

    // Reference history: most recent accepted value at index 0, cleared by reset.
    bus3_t       h3[$];
    logic [31:0] h1[$];
    bus3_t       e3[$];
    bus3_t       e2[$];
    logic [31:0] e1[$];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(RETIME_ON))
        u_d3 (.clk(clk), .reset(reset), .en(en), .in(in3), .out(out3));
    dff_pipe #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(2), .RETIME_STATUS(RETIME_OFF))
        u_d2 (.clk(clk), .reset(reset), .en(en), .in(in3), .out(out2));
    dff_pipe #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(1), .RETIME_STATUS(RETIME_OFF))
        u_d1 (.clk(clk), .reset(reset), .en(en), .in(in1), .out(out1));
    dff_pipe #(.WIDTH(1), .ARRAY_SIZE1(2), .ARRAY_SIZE2(1), .PIPE_DEPTH(0), .RETIME_STATUS(RETIME_OFF))
        u_d0 (.clk(clk), .reset(reset), .en(en), .in(in0), .out(out0));

    function automatic bus3_t fill(input int v);
        bus3_t b;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                b[i][j] = 24'(v);
        return b;
    endfunction

    function automatic bus3_t ramp(input int t);
        bus3_t b;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                b[i][j] = 24'(t * 9 + i * 3 + j);
        return b;
    endfunction

    function automatic bus3_t rand3();
        bus3_t b;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                b[i][j] = 24'($urandom);
        return b;
    endfunction

    task automatic check0(input logic [1:0] expv);
        checks++;
        if (out0 !== bus0_t'(expv)) begin
            failures++;
            $display("FAIL out_d0 t=%0t got=%b exp=%b", $time, out0, expv);
        end
    endtask

    // Drive one cycle, probe the zero-delay path twice mid-cycle, then advance the model.
    task automatic step(input logic r, input logic e, input bus3_t d3, input logic [31:0] d1);
        bus3_t x3;
        bus3_t x2;
        logic [31:0] x1;
        @(negedge clk);
        reset = r;
        en    = e;
        in3   = d3;
        in1   = bus1_t'(d1);
        for (int k = 0; k < 2; k++) begin
            logic [1:0] v;
            v   = 2'($urandom_range(0, 3));
            in0 = bus0_t'(v);
            #1;
            check0(v);
        end
        @(posedge clk);
        if (r) begin
            h3.delete();
            h1.delete();
        end else if (e) begin
            h3.push_front(d3);
            h1.push_front(d1);
            if (h3.size() > 4) void'(h3.pop_back());
            if (h1.size() > 4) void'(h1.pop_back());
        end
        x3 = '0;
        x2 = '0;
        x1 = '0;
        if (h3.size() >= 3) x3 = h3[2];
        if (h3.size() >= 2) x2 = h3[1];
        if (h1.size() >= 1) x1 = h1[0];
        e3.push_back(x3);
        e2.push_back(x2);
        e1.push_back(x1);
    endtask

    // Monitor: registered outputs are compared half a cycle after each edge.
    always @(negedge clk) begin
        bus3_t       x3;
        bus3_t       x2;
        logic [31:0] x1;
        if (e3.size() > 0) begin
            x3 = e3.pop_front();
            x2 = e2.pop_front();
            x1 = e1.pop_front();
            checks++;
            if (out3 !== x3) begin
                failures++;
                $display("FAIL out_d3 t=%0t got=%h exp=%h", $time, out3, x3);
            end
            checks++;
            if (out2 !== x2) begin
                failures++;
                $display("FAIL out_d2 t=%0t got=%h exp=%h", $time, out2, x2);
            end
            checks++;
            if (out1 !== bus1_t'(x1)) begin
                failures++;
                $display("FAIL out_d1 t=%0t got=%h exp=%h", $time, out1, x1);
            end
        end
    end

    initial begin
        int diffs;
        reset = 1'b1;
        en    = 1'b0;
        in3   = '0;
        in1   = '0;
        in0   = '0;

        // Reset for two cycles, then 5 on the depth-1 instance; ramp on the array instances.
        step(1'b1, 1'b0, fill(0), 32'd0);
        step(1'b1, 1'b1, fill(0), 32'd0);
        for (int t = 0; t < 8; t++)
            step(1'b0, 1'b1, ramp(t), (t == 0) ? 32'd5 : 32'(t + 100));

        // Stall with a poison value on the input.
        step(1'b1, 1'b0, fill(0), 32'd0);
        step(1'b0, 1'b1, fill(1), 32'd1);
        step(1'b0, 1'b1, fill(2), 32'd2);
        step(1'b0, 1'b1, fill(3), 32'd3);
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b0, fill(9), 32'd9);
        for (int k = 4; k < 8; k++)
            step(1'b0, 1'b1, fill(k), 32'(k));

        // Mid-stream reset while 7 and 8 are in flight.
        step(1'b0, 1'b1, fill(7), 32'd7);
        step(1'b0, 1'b1, fill(8), 32'd8);
        step(1'b1, 1'b1, fill(10), 32'd10);
        for (int k = 11; k < 16; k++)
            step(1'b0, 1'b1, fill(k), 32'(k));

        // Depth 3 vs depth 2 on an A->B change: exactly one differing cycle.
        diffs = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, fill(24'hA0A0A), 32'd0);
            #1;
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, fill(24'hB0B0B), 32'd0);
            #1;
            if (out3 !== out2) diffs++;
        end
        checks++;
        if (diffs != 1) begin
            failures++;
            $display("FAIL ab_diff_cycles got=%0d exp=1", diffs);
        end

        // Randomized traffic with occasional stalls and resets.
        for (int k = 0; k < 300; k++)
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75, rand3(), $urandom);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
